// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the memory bus arbiter: access size encoding, arbiter
//   FSM states and grant identifiers. Also provides the alignment test used
//   when the build defines MEM_ALIGN_CHECK_EN.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    // HALF needs an even offset, WORD needs offset 0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (size == SIZE_HALF)
            r = off[0];
        else if (size == SIZE_WORD)
            r = (off != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_lane_steer.sv
// mem_lane_steer
//   Combinational big-endian byte-lane steering between CPU-order data and
//   the little-lane-numbered 32-bit bus (lane k = bits [8k+7:8k] = byte at
//   base+k).
//   Ports:
//     i_size   access size (mem_size_t encoding; 3 treated as WORD)
//     i_off    byte offset within the word (HALF uses only bit 1)
//     i_signed sign-extend sub-word read values
//     i_wdata  right-justified store data
//     i_rdata  raw bus read data
//     o_be     byte enables
//     o_wdata  lane-steered write data, unused lanes zero
//     o_rdata  CPU-order read value, extended to 32 bits
module mem_lane_steer
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_hoff;
    logic [7:0]  w_byte;
    logic [15:0] w_half_raw;
    logic [15:0] w_half;

    always_comb begin
        // Half-word offset is truncated to even, so an odd HALF offset
        // behaves like the aligned half that contains it.
        w_hoff     = {i_off[1], 1'b0};
        w_byte     = i_rdata[{i_off, 3'b000} +: 8];
        w_half_raw = i_rdata[{w_hoff, 3'b000} +: 16];
        // lane o is the most significant byte of the value
        w_half     = {w_half_raw[7:0], w_half_raw[15:8]};

        o_be    = 4'b1111;
        o_wdata = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};
        o_rdata = {i_rdata[7:0], i_rdata[15:8], i_rdata[23:16], i_rdata[31:24]};

        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {24'd0, i_wdata[7:0]} << {i_off, 3'b000};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be    = 4'b0011 << w_hoff;
                o_wdata = {16'd0, i_wdata[7:0], i_wdata[15:8]} << {w_hoff, 3'b000};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: begin
                // WORD: full byte swap set above; offset ignored
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one Avalon-MM master between instruction fetch (IF) and data
//   load/store (D). Round-robin on ties, one transfer at a time through
//   IDLE -> BUS -> ACK, with big-endian lane steering so the core only sees
//   CPU-order data.
//   Optional build macro: MEM_ALIGN_CHECK_EN adds d_misaligned; misaligned
//   D requests then skip the bus and are acknowledged with d_misaligned=1.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     if_req/if_addr        fetch request (always a WORD read)
//     if_ack/if_rdata       fetch done pulse / instruction
//     d_req/d_we/d_addr/d_size/d_signed/d_wdata   data request
//     d_ack/d_rdata         data done pulse / load result
//     address/read/write/byteenable/writedata     registered Avalon outputs
//     waitrequest/readdata  Avalon inputs
//     d_misaligned          (MEM_ALIGN_CHECK_EN only) misaligned access flag
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        d_misaligned
`endif
);

    arb_state_t  r_state;
    grant_t      r_grant;
    grant_t      r_last;
    logic [31:0] r_address;
    logic        r_read;
    logic        r_write;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    // read-steering parameters latched at grant
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_sgn;
`ifdef MEM_ALIGN_CHECK_EN
    logic        r_misaligned;
`endif

    logic        w_any;
    logic        w_pick_d;
    logic [31:0] w_pick_addr;
    logic [1:0]  w_pick_off;
    logic [1:0]  w_pick_size;
    logic        w_pick_sgn;
    logic        w_pick_we;
    logic        w_mis;
    logic [1:0]  w_st_size;
    logic [1:0]  w_st_off;
    logic        w_st_sgn;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    always_comb begin
        w_any       = if_req | d_req;
        // D wins a tie unless it had the previous grant
        w_pick_d    = d_req & (~if_req | (r_last == GRANT_IF));
        w_pick_addr = w_pick_d ? d_addr : if_addr;
        w_pick_off  = w_pick_d ? w_pick_addr[1:0] : 2'b00;
        w_pick_size = w_pick_d ? d_size : SIZE_WORD;
        w_pick_sgn  = w_pick_d & d_signed;
        w_pick_we   = w_pick_d & d_we;
`ifdef MEM_ALIGN_CHECK_EN
        w_mis       = w_pick_d & is_misaligned(d_size, d_addr[1:0]);
`else
        w_mis       = 1'b0;
`endif
        // One steering unit: in IDLE it shapes the request being granted,
        // afterwards it decodes readdata for the latched request.
        if (r_state == ARB_IDLE) begin
            w_st_size = w_pick_size;
            w_st_off  = w_pick_off;
            w_st_sgn  = w_pick_sgn;
        end else begin
            w_st_size = r_size;
            w_st_off  = r_off;
            w_st_sgn  = r_sgn;
        end
    end

    mem_lane_steer u_steer (
        .i_size   (w_st_size),
        .i_off    (w_st_off),
        .i_signed (w_st_sgn),
        .i_wdata  (d_wdata),
        .i_rdata  (readdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_grant      <= GRANT_IF;
            r_last       <= GRANT_IF;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= '0;
            r_writedata  <= '0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_size       <= '0;
            r_off        <= '0;
            r_sgn        <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            // acks and the misaligned flag are single-cycle pulses
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick_d ? GRANT_D : GRANT_IF;
                        r_size  <= w_pick_size;
                        r_off   <= w_pick_off;
                        r_sgn   <= w_pick_sgn;
                        if (w_mis) begin
`ifdef MEM_ALIGN_CHECK_EN
                            r_misaligned <= 1'b1;
`endif
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= '0;
                            r_state   <= ARB_ACK;
                        end else begin
                            r_address    <= {w_pick_addr[31:2], 2'b00};
                            r_read       <= ~w_pick_we;
                            r_write      <= w_pick_we;
                            r_byteenable <= w_be;
                            r_writedata  <= w_pick_we ? w_wdata : 32'd0;
                            r_state      <= ARB_BUS;
                        end
                    end
                end
                ARB_BUS: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            if (r_grant == GRANT_D)
                                r_d_rdata <= w_rdata;
                            else
                                r_if_rdata <= w_rdata;
                        end
                        if (r_grant == GRANT_D)
                            r_d_ack <= 1'b1;
                        else
                            r_if_ack <= 1'b1;
                        r_state <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    r_last  <= r_grant;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_byteenable;
    assign writedata  = r_writedata;
    assign if_ack     = r_if_ack;
    assign d_ack      = r_d_ack;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    assign d_misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        d_misaligned;
`endif

    mem_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_size      (d_size),
        .d_signed    (d_signed),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .d_misaligned(d_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic        sgn;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic        ld;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[14];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    // Present a request and record what its ack must deliver.
    task automatic drive(input vec_t v);
        sb_t e;
        e.is_d = v.is_d; e.ld = ~v.we; e.rdata = v.exp_rdata;
        sb_q.push_back(e);
        if (v.is_d) begin
            d_we = v.we; d_addr = v.addr; d_size = v.size;
            d_signed = v.sgn; d_wdata = v.wdata; d_req = 1'b1;
        end else begin
            if_addr = v.addr; if_req = 1'b1;
        end
    endtask

    // Act as the Avalon slave for one transfer, then check the ack.
    task automatic serve(input vec_t v, input bit drop_early, input int exp_lat);
        int  n;
        bit  got;
        sb_t e;
        waitrequest = 1'b1; readdata = 32'hDEADBEEF;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++; got = read | write;
        end
        chk("strobe_seen", {31'd0, got}, 32'd1);
        if (got) begin
            if (exp_lat > 0) chk("strobe_latency", n, exp_lat);
            chk("address", address, v.exp_addr);
            chk("byteenable", {28'd0, byteenable}, {28'd0, v.exp_be});
            chk("writedata", writedata, v.exp_wdata);
            chk("write", {31'd0, write}, {31'd0, v.we});
            chk("read", {31'd0, read}, {31'd0, ~v.we});
            if (drop_early) begin
                if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
            end
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                chk("hold_strobe", {31'd0, read | write}, 32'd1);
                chk("hold_address", address, v.exp_addr);
                chk("hold_no_ack", {31'd0, if_ack | d_ack}, 32'd0);
            end
            waitrequest = 1'b0; readdata = v.rdata;
            n = 0; got = 0;
            while (!got && n < 20) begin
                @(negedge clk); n++; got = if_ack | d_ack;
            end
            waitrequest = 1'b1; readdata = 32'hDEADBEEF;
            chk("ack_seen", {31'd0, got}, 32'd1);
            chk("ack_latency", n, 32'd1);
            chk("no_strobe_at_ack", {31'd0, read | write}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            chk("misaligned_low", {31'd0, d_misaligned}, 32'd0);
`endif
            if (sb_q.size() == 0) begin
                chk("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("d_ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
                chk("if_ack_owner", {31'd0, if_ack}, {31'd0, ~e.is_d});
                if (e.ld) begin
                    if (e.is_d) chk("d_rdata", d_rdata, e.rdata);
                    else        chk("if_rdata", if_rdata, e.rdata);
                end
                if (e.is_d) d_req = 1'b0; else if_req = 1'b0;
            end
            @(negedge clk);
            chk("ack_pulse_end", {31'd0, if_ack | d_ack}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit drop_early);
        @(negedge clk);
        drive(v);
        serve(v, drop_early, 1);
    endtask

    task automatic run_tie(input vec_t vf, input vec_t vs);
        @(negedge clk);
        drive(vf);
        drive(vs);
        serve(vf, 0, 1);
        serve(vs, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vec_t tf, ts, tv;
        int   n;
        bit   got;

        //          is_d we  sgn size       addr          wdata         rdata        w  exp_addr      be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b0,1'b0,1'b0,SIZE_WORD,32'hBFC00000,32'h0,        32'h78563412,0, 32'hBFC00000,4'b1111,32'h0,        32'h12345678};
        vecs[1]  = '{1'b1,1'b0,1'b1,SIZE_BYTE,32'h00001003,32'h0,        32'h80000000,0, 32'h00001000,4'b1000,32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1,1'b0,1'b0,SIZE_BYTE,32'h00001003,32'h0,        32'h80000000,0, 32'h00001000,4'b1000,32'h0,        32'h00000080};
        vecs[3]  = '{1'b1,1'b1,1'b0,SIZE_HALF,32'h00002002,32'h0000ABCD,32'h0,        0, 32'h00002000,4'b1100,32'hCDAB0000,32'h0};
        vecs[4]  = '{1'b1,1'b0,1'b0,SIZE_WORD,32'h00003000,32'h0,        32'hAABBCCDD,2, 32'h00003000,4'b1111,32'h0,        32'hDDCCBBAA};
        vecs[5]  = '{1'b1,1'b0,1'b1,SIZE_HALF,32'h00004000,32'h0,        32'h0000FF80,0, 32'h00004000,4'b0011,32'h0,        32'hFFFF80FF};
        vecs[6]  = '{1'b1,1'b0,1'b0,SIZE_HALF,32'h00004002,32'h0,        32'h80FF0000,1, 32'h00004000,4'b1100,32'h0,        32'h0000FF80};
        vecs[7]  = '{1'b1,1'b1,1'b0,SIZE_BYTE,32'h00005001,32'h123456A5,32'h0,        0, 32'h00005000,4'b0010,32'h0000A500,32'h0};
        vecs[8]  = '{1'b1,1'b1,1'b0,SIZE_WORD,32'h00006004,32'h11223344,32'h0,        1, 32'h00006004,4'b1111,32'h44332211,32'h0};
        vecs[9]  = '{1'b1,1'b0,1'b1,SIZE_BYTE,32'h00007000,32'h0,        32'hFFFFFF5A,0, 32'h00007000,4'b0001,32'h0,        32'h0000005A};
        vecs[10] = '{1'b1,1'b0,1'b1,SIZE_BYTE,32'h00007002,32'h0,        32'h00C30000,0, 32'h00007000,4'b0100,32'h0,        32'hFFFFFFC3};
        vecs[11] = '{1'b0,1'b0,1'b0,SIZE_WORD,32'h00400010,32'h0,        32'h0C000008,3, 32'h00400010,4'b1111,32'h0,        32'h0800000C};
        vecs[12] = '{1'b1,1'b0,1'b0,SIZE_BYTE,32'h00007001,32'h0,        32'h0000A500,0, 32'h00007000,4'b0010,32'h0,        32'h000000A5};
        vecs[13] = '{1'b1,1'b1,1'b0,SIZE_HALF,32'h00002000,32'hFFFF1234,32'h0,        0, 32'h00002000,4'b0011,32'h00003412,32'h0};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_size = SIZE_WORD; d_signed = 1'b0; d_wdata = '0;
        waitrequest = 1'b1; readdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // First tie after reset: D first (held 3 wait cycles), then IF.
        tf = '{1'b1,1'b0,1'b0,SIZE_WORD,32'h00008000,32'h0,32'h44332211,3,32'h00008000,4'b1111,32'h0,32'h11223344};
        ts = '{1'b0,1'b0,1'b0,SIZE_WORD,32'h00000100,32'h0,32'h27BDFFE8,0,32'h00000100,4'b1111,32'h0,32'hE8FFBD27};
        run_tie(tf, ts);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], 0);

`ifdef MEM_ALIGN_CHECK_EN
        // d_rdata holds 0xA5 from the last load, so the zero is observable.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00001001; d_size = SIZE_WORD; d_signed = 1'b0;
        @(negedge clk);
        chk("mis_d_ack", {31'd0, d_ack}, 32'd1);
        chk("mis_flag", {31'd0, d_misaligned}, 32'd1);
        chk("mis_d_rdata", d_rdata, 32'd0);
        chk("mis_no_strobe", {31'd0, read | write}, 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("mis_flag_drop", {31'd0, d_misaligned}, 32'd0);
        chk("mis_ack_drop", {31'd0, d_ack}, 32'd0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00002001; d_size = SIZE_HALF; d_wdata = 32'h1234;
        @(negedge clk);
        chk("mis_sh_ack", {31'd0, d_ack}, 32'd1);
        chk("mis_sh_no_write", {31'd0, write}, 32'd0);
        d_req = 1'b0;
`else
        // Without the check, an odd HALF offset truncates to the even half.
        tv = '{1'b1,1'b0,1'b0,SIZE_HALF,32'h00004003,32'h0,32'h80FF0000,0,32'h00004000,4'b1100,32'h0,32'h0000FF80};
        run_vec(tv, 0);
        tv = '{1'b1,1'b0,1'b0,SIZE_WORD,32'h00003002,32'h0,32'hAABBCCDD,0,32'h00003000,4'b1111,32'h0,32'hDDCCBBAA};
        run_vec(tv, 0);
`endif

        // Fetch whose requester drops req once the strobe is up.
        tv = '{1'b0,1'b0,1'b0,SIZE_WORD,32'h00000200,32'h0,32'hAB000000,1,32'h00000200,4'b1111,32'h0,32'h000000AB};
        run_vec(tv, 1);

        // Reset while stalled in BUS: strobe drops, no ack ever appears.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00009000; d_size = SIZE_WORD;
        waitrequest = 1'b1;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++; got = read;
        end
        chk("rstmid_strobe_seen", {31'd0, got}, 32'd1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rstmid_read_low", {31'd0, read}, 32'd0);
        reset = 1'b0; waitrequest = 1'b0;
        got = 0;
        repeat (4) begin
            @(negedge clk); got = got | if_ack | d_ack | read | write;
        end
        chk("rstmid_no_ack", {31'd0, got}, 32'd0);

        // last-grant was reset to IF, so the next tie goes to D again.
        tf = '{1'b1,1'b0,1'b1,SIZE_HALF,32'h0000A000,32'h0,32'h0000FE01,0,32'h0000A000,4'b0011,32'h0,32'h000001FE};
        ts = '{1'b0,1'b0,1'b0,SIZE_WORD,32'h00000300,32'h0,32'h00000001,0,32'h00000300,4'b1111,32'h0,32'h01000000};
        run_tie(tf, ts);

        // After a D-only transfer the tie goes to IF.
        run_vec(vecs[2], 0);
        tf = '{1'b0,1'b0,1'b0,SIZE_WORD,32'h00000104,32'h0,32'h01020304,0,32'h00000104,4'b1111,32'h0,32'h04030201};
        ts = '{1'b1,1'b1,1'b0,SIZE_BYTE,32'h0000A003,32'h00000077,32'h0,0,32'h0000A000,4'b1000,32'h77000000,32'h0};
        run_tie(tf, ts);

        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single Avalon-MM master bus of mips_cpu_bus between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each transfer through the waitrequest handshake.
- Performs big-endian byte-lane steering for byte, half and word accesses, so the core sees CPU-order data and never handles byteenable or byte-swapping itself.

Parameters:
- none (bus fixed at 32-bit address, 32-bit data)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  32  fetch byte address (word-aligned)
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  32  fetched instruction, CPU byte order
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_size  in  2  mem_size_t: BYTE / HALF / WORD
d_signed  in  1  sign-extend sub-word loads
d_wdata  in  32  store data, right-justified
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load result, extended to 32 bits
address  out  32  Avalon address, always {addr[31:2], 2'b00}
read  out  1  Avalon read strobe
write  out  1  Avalon write strobe
waitrequest  in  1  Avalon stall
writedata  out  32  Avalon write data, lane-steered
byteenable  out  4  Avalon byte enables
readdata  in  32  Avalon read data

Behaviour:
- Bus outputs (address, read, write, byteenable, writedata) are registered. They change only on state transitions.
- Reset values: read=0, write=0, address=0, byteenable=0, writedata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0; state IDLE; last-grant = IF.
- States:
  - IDLE: sample if_req/d_req. If neither is asserted, stay.
  - IDLE, one request: grant it.
  - IDLE, both requests: round-robin against last-grant, so D wins on the first tie after reset. Load bus registers, go to BUS.
  - BUS: strobe asserted; all bus outputs held stable while waitrequest=1. The cycle with waitrequest=0 completes the transfer: readdata is steered and registered into the granted requester's rdata, strobe drops, go to ACK.
  - ACK: pulse the granted requester's ack for exactly one cycle, update last-grant, return to IDLE.
- Minimum latency from req to ack is 3 cycles (IDLE, BUS, ACK) when waitrequest=0. Each additional waitrequest cycle adds one.
- Requests are sampled only in IDLE. Changing req/addr/wdata while granted is illegal; the block uses the values latched at grant.
- A requester that drops req before ack is still acknowledged; its transfer completes.
- Lane steering, where lane k = byte at base+k and lane k is bits [8k+7:8k]; o = d_addr[1:0]:
  - WORD: byteenable=1111; read value = {lane0,lane1,lane2,lane3}; writedata is the same swap.
  - HALF: byteenable=0011 (o=0) or 1100 (o=2); value = {lane o, lane o+1}; zero- or sign-extended per d_signed.
  - BYTE: byteenable = 1<<o; value = lane o, extended; store places d_wdata[7:0] on lane o.
  - Unused writedata lanes are driven 0.
- Fetch is always a WORD read.
- Reset mid-operation: strobes are low from the next edge, any pending ack is discarded, state returns to IDLE.
- read and write are never asserted together. A new transfer never starts in the cycle an ack is asserted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds an output d_misaligned (1 bit).
  - A misaligned D request (HALF with o odd, or WORD with o≠0) skips BUS and goes IDLE→ACK.
  - In that ACK cycle: d_ack=1, d_misaligned=1, d_rdata=0, and there is no bus strobe.
  - d_misaligned is 0 at all other times.
- Undefined: the port is absent; misaligned offsets are truncated (HALF uses addr[1], WORD ignores addr[1:0]).

Decomposition:
- Package (package.v): mem_size_t (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2); arb_state_t (ARB_IDLE, ARB_BUS, ARB_ACK); grant_t (GRANT_IF, GRANT_D).
- Sub-module mem_lane_steer: combinational. Computes byteenable, steered writedata and extended read value from size, offset, signed, wdata and readdata. It replaces toggle_endianness for bus traffic.

Test Plan:
- Fetch at 0xBFC00000, readdata=0x78563412, waitrequest=0 → read=1 for 1 cycle, address=0xBFC00000, if_ack 3 cycles after if_req, if_rdata=0x12345678.
- Simultaneous if_req and d_req after reset, then both again → D granted first, IF second; 1 cycle of read with waitrequest=1 for 3 cycles → address/read held, d_ack delayed 3 cycles.
- Signed LB at 0x1003, readdata=0x80000000 → byteenable=1000, d_rdata=0xFFFFFF80; unsigned gives 0x00000080.
- SH at 0x2002, d_wdata=0x0000ABCD → write=1, byteenable=1100, writedata=0xCDAB0000, d_ack pulse.
- Reset asserted while in BUS with waitrequest=1 → read=0 next cycle, no ack, next request is served normally.
- MEM_ALIGN_CHECK_EN defined: LW at 0x1001 → no strobe, d_ack=1 and d_misaligned=1 two cycles after d_req, d_rdata=0.
